memory_access_stage: RTL and testbench

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

---
 rtl/memory_access_stage.sv | 148 ++++++++++++++
 tb/tb_memory_access_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// ----------------------------------------------------------------------------
// memory_access_stage
//
// Pipeline MEM stage that sequences one data-memory access per EX/MEM
// instruction through a small IDLE -> BUSY -> DONE machine. It stalls the
// pipeline until the memory acknowledges or a timeout expires. Store data is
// forwarded from MEM/WB when the store source register is being written back.
//
// Memory handshake: o_dmem_req rises on the edge that enters BUSY and stays
// high, with o_dmem_we/o_dmem_addr/o_dmem_wdata held constant, until the edge
// after the cycle in which i_dmem_ack is sampled high (a one-cycle pulse) or
// the timeout fires. i_dmem_rdata is only looked at while i_dmem_ack=1, and
// i_dmem_ack is ignored outside BUSY.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_mem_read_xm         EX/MEM load in flight
//   i_mem_write_xm        EX/MEM store in flight (wins over read)
//   i_addr_xm             word address
//   i_store_data_xm       store operand from EX/MEM
//   i_store_reg_xm        source register of the store operand
//   i_reg_write_mw        MEM/WB write enable
//   i_write_reg_mw        MEM/WB destination register
//   i_wb_data_mw          MEM/WB writeback value
//   i_dmem_ack            memory completion pulse
//   i_dmem_rdata          memory read data
//   o_dmem_req/we/addr/wdata  registered memory request
//   o_mem_data_xm         load result (buffer while DONE, else 0)
//   o_stall               combinational pipeline freeze
//   o_bus_err             sticky timeout flag
//   o_state               current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// ----------------------------------------------------------------------------
module memory_access_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_read_xm,
  input  logic        i_mem_write_xm,
  input  logic [15:0] i_addr_xm,
  input  logic [15:0] i_store_data_xm,
  input  logic [3:0]  i_store_reg_xm,
  input  logic        i_reg_write_mw,
  input  logic [3:0]  i_write_reg_mw,
  input  logic [15:0] i_wb_data_mw,
  input  logic        i_dmem_ack,
  input  logic [15:0] i_dmem_rdata,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [15:0] o_dmem_addr,
  output logic [15:0] o_dmem_wdata,
  output logic [15:0] o_mem_data_xm,
  output logic        o_stall,
  output logic        o_bus_err,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Last counter value allowed in BUSY before the access is abandoned.
  localparam logic [3:0] LP_LAST = 4'(TIMEOUT - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_req;
  logic        r_we;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_buf;
  logic        r_bus_err;

  logic        w_access;
  logic        w_fwd_hit;
  logic [15:0] w_fwd_data;

  assign w_access = i_mem_read_xm | i_mem_write_xm;

  // Register 0 is hardwired, so a write-back to it never forwards.
  assign w_fwd_hit  = i_mem_write_xm & i_reg_write_mw &
                      (i_write_reg_mw == i_store_reg_xm) &
                      (i_store_reg_xm != 4'd0);
  assign w_fwd_data = w_fwd_hit ? i_wb_data_mw : i_store_data_xm;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 16'h0000;
      r_wdata   <= 16'h0000;
      r_buf     <= 16'h0000;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            // Forwarding is sampled only here; wdata then stays frozen.
            r_state <= ST_BUSY;
            r_req   <= 1'b1;
            r_we    <= i_mem_write_xm;
            r_addr  <= i_addr_xm;
            r_wdata <= w_fwd_data;
            r_cnt   <= 4'd0;
          end
        end
        ST_BUSY: begin
          if (i_dmem_ack) begin
            // Ack beats a coincident timeout: data kept, no error raised.
            r_state <= ST_DONE;
            r_req   <= 1'b0;
            if (!r_we) begin
              r_buf <= i_dmem_rdata;
            end
          end else if (r_cnt == LP_LAST) begin
            r_state   <= ST_DONE;
            r_req     <= 1'b0;
            r_buf     <= 16'hFFFF;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign o_stall       = ((r_state == ST_IDLE) & w_access) | (r_state == ST_BUSY);
  assign o_mem_data_xm = (r_state == ST_DONE) ? r_buf : 16'h0000;
  assign o_dmem_req    = r_req;
  assign o_dmem_we     = r_we;
  assign o_dmem_addr   = r_addr;
  assign o_dmem_wdata  = r_wdata;
  assign o_bus_err     = r_bus_err;
  assign o_state       = r_state;

endmodule

// File: tb/tb_memory_access_stage.sv
module tb_memory_access_stage;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int NO_ACK = 99;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read_xm = 1'b0;
  logic        mem_write_xm = 1'b0;
  logic [15:0] addr_xm = 16'h0;
  logic [15:0] store_data_xm = 16'h0;
  logic [3:0]  store_reg_xm = 4'h0;
  logic        reg_write_mw = 1'b0;
  logic [3:0]  write_reg_mw = 4'h0;
  logic [15:0] wb_data_mw = 16'h0;
  logic        dmem_ack = 1'b0;
  logic [15:0] dmem_rdata = 16'h0;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] mem_data_xm;
  logic        stall;
  logic        bus_err;
  logic [1:0]  state;

  memory_access_stage #(.TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mem_read_xm(mem_read_xm), .i_mem_write_xm(mem_write_xm),
    .i_addr_xm(addr_xm), .i_store_data_xm(store_data_xm),
    .i_store_reg_xm(store_reg_xm), .i_reg_write_mw(reg_write_mw),
    .i_write_reg_mw(write_reg_mw), .i_wb_data_mw(wb_data_mw),
    .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
    .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
    .o_mem_data_xm(mem_data_xm), .o_stall(stall),
    .o_bus_err(bus_err), .o_state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] sdata;
    logic [3:0]  sreg;
    logic        rw;
    logic [3:0]  wreg;
    logic [15:0] wb;
    int          ack_at;
    logic [15:0] rdata;
    logic [15:0] exp_wdata;
    logic [15:0] exp_data;
    int          exp_stall;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic rd, logic wr, logic [15:0] addr,
                              logic [15:0] sdata, logic [3:0] sreg,
                              logic rw, logic [3:0] wreg, logic [15:0] wb,
                              int ack_at, logic [15:0] rdata,
                              logic [15:0] exp_wdata, logic [15:0] exp_data,
                              int exp_stall, logic exp_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.sdata = sdata; v.sreg = sreg;
    v.rw = rw; v.wreg = wreg; v.wb = wb; v.ack_at = ack_at; v.rdata = rdata;
    v.exp_wdata = exp_wdata; v.exp_data = exp_data;
    v.exp_stall = exp_stall; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one access from IDLE and follows it to DONE and back to IDLE.
  task automatic run_txn(input int idx, input vec_t v);
    int stall_cnt;
    int busy_idx;
    int guard;
    bit done;
    logic [15:0] exp_d;
    mem_read_xm   = v.rd;
    mem_write_xm  = v.wr;
    addr_xm       = v.addr;
    store_data_xm = v.sdata;
    store_reg_xm  = v.sreg;
    reg_write_mw  = v.rw;
    write_reg_mw  = v.wreg;
    wb_data_mw    = v.wb;
    exp_q.push_back(v.exp_data);
    #1;
    chk($sformatf("v%0d_issue_stall", idx), stall, 1);
    stall_cnt = 0;
    busy_idx  = 0;
    guard     = 0;
    done      = 0;
    while (!done && guard < 40) begin
      if (stall) stall_cnt++;
      tick();
      guard++;
      if (state == S_BUSY) begin
        if (busy_idx == 0) begin
          chk($sformatf("v%0d_req", idx), dmem_req, 1);
          chk($sformatf("v%0d_we", idx), dmem_we, v.wr);
          chk($sformatf("v%0d_addr", idx), dmem_addr, v.addr);
          chk($sformatf("v%0d_wdata", idx), dmem_wdata, v.exp_wdata);
          // pipeline has moved on upstream: later MEM/WB values must not leak in
          mem_read_xm   = 1'b0;
          mem_write_xm  = 1'b0;
          wb_data_mw    = ~v.wb;
          store_data_xm = ~v.sdata;
        end
        dmem_ack   = (busy_idx == v.ack_at);
        dmem_rdata = (busy_idx == v.ack_at) ? v.rdata : 16'hDEAD;
        busy_idx++;
        #1;
      end else if (state == S_DONE) begin
        done = 1;
        dmem_ack = 1'b0;
        #1;
        exp_d = exp_q.pop_front();
        chk($sformatf("v%0d_done_stall", idx), stall, 0);
        chk($sformatf("v%0d_mem_data", idx), mem_data_xm, exp_d);
        chk($sformatf("v%0d_done_req", idx), dmem_req, 0);
        chk($sformatf("v%0d_bus_err", idx), bus_err, v.exp_err);
        chk($sformatf("v%0d_wdata_held", idx), dmem_wdata, v.exp_wdata);
      end else begin
        chk($sformatf("v%0d_unexpected_state", idx), state, S_BUSY);
        guard = 40;
      end
    end
    chk($sformatf("v%0d_reached_done", idx), done, 1);
    chk($sformatf("v%0d_stall_cycles", idx), stall_cnt, v.exp_stall);
    tick();
    chk($sformatf("v%0d_back_idle", idx), state, S_IDLE);
    chk($sformatf("v%0d_idle_data", idx), mem_data_xm, 16'h0000);
    chk($sformatf("v%0d_idle_stall", idx), stall, 0);
  endtask

  initial begin
    //          rd wr addr     sdata    sreg rw wreg wb       ack     rdata    exp_wd   exp_d    stl err
    vecs[0]  = mk(1, 0, 16'h0040, 16'h0000, 3, 0, 0, 16'h0000, 2,      16'hBEEF, 16'h0000, 16'hBEEF, 4,  0);
    vecs[1]  = mk(0, 1, 16'h0041, 16'h9999, 3, 1, 3, 16'h1234, 1,      16'hDEAD, 16'h1234, 16'hBEEF, 3,  0);
    vecs[2]  = mk(0, 1, 16'h0042, 16'h9999, 0, 1, 0, 16'h1234, 0,      16'hDEAD, 16'h9999, 16'hBEEF, 2,  0);
    vecs[3]  = mk(0, 1, 16'h0043, 16'h5555, 3, 0, 3, 16'h1234, 0,      16'hDEAD, 16'h5555, 16'hBEEF, 2,  0);
    vecs[4]  = mk(0, 1, 16'h0044, 16'h5555, 3, 1, 4, 16'h1234, 0,      16'hDEAD, 16'h5555, 16'hBEEF, 2,  0);
    vecs[5]  = mk(1, 0, 16'h0100, 16'h7777, 5, 1, 5, 16'h4321, 0,      16'h1111, 16'h7777, 16'h1111, 2,  0);
    vecs[6]  = mk(1, 1, 16'h0101, 16'h2468, 6, 1, 6, 16'hABCD, 3,      16'h9876, 16'hABCD, 16'h1111, 5,  0);
    vecs[7]  = mk(1, 0, 16'h0200, 16'h0000, 0, 0, 0, 16'h0000, 0,      16'hA5A5, 16'h0000, 16'hA5A5, 2,  0);
    vecs[8]  = mk(1, 0, 16'h0201, 16'h0000, 0, 0, 0, 16'h0000, 0,      16'h5A5A, 16'h0000, 16'h5A5A, 2,  0);
    vecs[9]  = mk(1, 0, 16'h0300, 16'h0000, 0, 0, 0, 16'h0000, 14,     16'h0F0F, 16'h0000, 16'h0F0F, 16, 0);
    vecs[10] = mk(1, 0, 16'h0400, 16'h0000, 0, 0, 0, 16'h0000, NO_ACK, 16'h0000, 16'h0000, 16'hFFFF, 16, 1);
    vecs[11] = mk(1, 0, 16'h0500, 16'h0000, 0, 0, 0, 16'h0000, 0,      16'h2222, 16'h0000, 16'h2222, 2,  1);
    vecs[12] = mk(0, 1, 16'h0501, 16'h3C3C, 7, 1, 7, 16'hC3C3, 1,      16'hDEAD, 16'hC3C3, 16'h2222, 3,  1);
    // used after the mid-BUSY reset: buffer was cleared, store leaves it at 0
    vecs[13] = mk(0, 1, 16'h0600, 16'h0BAD, 2, 0, 2, 16'h0000, 0,      16'hDEAD, 16'h0BAD, 16'h0000, 2,  0);

    // reset state
    #2;
    chk("rst_state", state, S_IDLE);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 16'h0);
    chk("rst_wdata", dmem_wdata, 16'h0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mem_data", mem_data_xm, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // stray ack while IDLE is ignored
    dmem_ack = 1'b1;
    dmem_rdata = 16'h3333;
    tick();
    dmem_ack = 1'b0;
    chk("stray_ack_state", state, S_IDLE);
    chk("stray_ack_data", mem_data_xm, 16'h0);

    for (int i = 0; i < 13; i++) begin
      run_txn(i, vecs[i]);
    end

    // reset in the middle of BUSY, then a late ack after release
    mem_read_xm = 1'b1;
    addr_xm = 16'h0700;
    tick();
    chk("mid_rst_busy", state, S_BUSY);
    mem_read_xm = 1'b0;
    tick();
    chk("mid_rst_req_before", dmem_req, 1);
    chk("mid_rst_err_before", bus_err, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_state", state, S_IDLE);
    chk("mid_rst_bus_err", bus_err, 0);
    chk("mid_rst_stall", stall, 0);
    tick();
    rst_n = 1'b1;
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 16'h7E7E;
    tick();
    dmem_ack = 1'b0;
    chk("late_ack_state", state, S_IDLE);
    chk("late_ack_req", dmem_req, 0);
    chk("late_ack_data", mem_data_xm, 16'h0);
    tick();
    chk("late_ack_state2", state, S_IDLE);

    run_txn(13, vecs[13]);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
